// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
// Shared constants and types for the vga_example mandala generator:
//   - 640x480 horizontal/vertical timing (visible, porches, sync, totals)
//   - screen centre used to fold coordinates
//   - pattern-select enumeration
//   - small helpers for the folded-coordinate arithmetic
// ---------------------------------------------------------------------------
package vga_pkg;

    localparam logic [9:0] H_VISIBLE = 10'd640;
    localparam logic [9:0] H_FRONT   = 10'd16;
    localparam logic [9:0] H_SYNC    = 10'd96;
    localparam logic [9:0] H_BACK    = 10'd48;
    localparam logic [9:0] H_TOTAL   = 10'd800;

    localparam logic [9:0] V_VISIBLE = 10'd480;
    localparam logic [9:0] V_FRONT   = 10'd10;
    localparam logic [9:0] V_SYNC    = 10'd2;
    localparam logic [9:0] V_BACK    = 10'd33;
    localparam logic [9:0] V_TOTAL   = 10'd525;

    localparam logic [9:0] H_CENTRE  = 10'd320;
    localparam logic [9:0] V_CENTRE  = 10'd240;

    // Idle output word: both syncs inactive (high), all colour bits zero.
    localparam logic [7:0] UO_IDLE   = 8'h88;

    typedef enum logic [1:0] {
        RINGS   = 2'd0,
        XOR     = 2'd1,
        PRODUCT = 2'd2,
        SQUARE  = 2'd3
    } pattern_e;

    // Distance of a counter from a centre; always fits in 9 bits for this raster.
    function automatic logic [8:0] abs_diff(input logic [9:0] x, input logic [9:0] c);
        logic [9:0] d;
        if (x >= c) begin
            d = x - c;
        end else begin
            d = c - x;
        end
        return d[8:0];
    endfunction

endpackage

// File: rtl/vga_if.sv
// ---------------------------------------------------------------------------
// vga_if
// Standard tile pin bundle (8-in / 8-out / 8-bidir plus enable).
//   ena     : tile enable
//   ui_in   : dedicated inputs ([1:0] pattern select)
//   uio_in  : bidirectional pins, input side
//   uo_out  : dedicated outputs {hsync,B0,G0,R0,vsync,B1,G1,R1}
//   uio_out : bidirectional pins, output side
//   uio_oe  : bidirectional output enables
// master = the tile's environment (drives inputs), slave = the design.
// ---------------------------------------------------------------------------
interface vga_if;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (
        output ena, ui_in, uio_in,
        input  uo_out, uio_out, uio_oe
    );

    modport slave (
        input  ena, ui_in, uio_in,
        output uo_out, uio_out, uio_oe
    );
endinterface

// File: rtl/vga_timing.sv
// ---------------------------------------------------------------------------
// vga_timing
// 800x525 raster counters for 640x480 VGA.
// Ports:
//   clk, rst_n  : pixel clock, asynchronous active-low reset
//   hcount      : 0..799, current column
//   vcount      : 0..524, current line
//   hsync/vsync : combinational active-low sync for the current position
//   visible     : current position lies in the 640x480 active area
//   frame_end   : last cycle of the frame (hcount=799, vcount=524)
// ---------------------------------------------------------------------------
module vga_timing
    import vga_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    output logic [9:0] hcount,
    output logic [9:0] vcount,
    output logic       hsync,
    output logic       vsync,
    output logic       visible,
    output logic       frame_end
);

    localparam logic [9:0] H_SYNC_START = H_VISIBLE + H_FRONT;
    localparam logic [9:0] H_SYNC_STOP  = H_VISIBLE + H_FRONT + H_SYNC;
    localparam logic [9:0] V_SYNC_START = V_VISIBLE + V_FRONT;
    localparam logic [9:0] V_SYNC_STOP  = V_VISIBLE + V_FRONT + V_SYNC;

    logic [9:0] hcount_q, hcount_d;
    logic [9:0] vcount_q, vcount_d;
    logic       h_last_s;
    logic       v_last_s;

    // Counter state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcount_q <= 10'd0;
            vcount_q <= 10'd0;
        end else begin
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
        end
    end

    // Next counter values: line wrap advances the line counter.
    always_comb begin
        h_last_s = (hcount_q == (H_TOTAL - 10'd1));
        v_last_s = (vcount_q == (V_TOTAL - 10'd1));
        hcount_d = hcount_q;
        vcount_d = vcount_q;
        if (h_last_s) begin
            hcount_d = 10'd0;
            if (v_last_s) begin
                vcount_d = 10'd0;
            end else begin
                vcount_d = vcount_q + 10'd1;
            end
        end else begin
            hcount_d = hcount_q + 10'd1;
        end
    end

    // Decoded raster flags for the current position.
    always_comb begin
        hsync     = !((hcount_q >= H_SYNC_START) && (hcount_q < H_SYNC_STOP));
        vsync     = !((vcount_q >= V_SYNC_START) && (vcount_q < V_SYNC_STOP));
        visible   = (hcount_q < H_VISIBLE) && (vcount_q < V_VISIBLE);
        frame_end = h_last_s && v_last_s;
    end

    assign hcount = hcount_q;
    assign vcount = vcount_q;

endmodule

// File: rtl/vga_example.sv
// ---------------------------------------------------------------------------
// vga_example
// Animated 8-fold-symmetric mandala on 640x480 VGA, 2 bits per colour.
// Ports:
//   clk    : pixel clock (rising edge)
//   rst_n  : asynchronous active-low reset
//   tile   : vga_if.slave pin bundle
//            ui_in[1:0] pattern select (latched at end of frame),
//            uo_out = {hsync,B0,G0,R0,vsync,B1,G1,R1} (registered),
//            uio_out / uio_oe tied to 0, ena / uio_in / ui_in[7:2] ignored.
// Configuration macro: VGA_ANIMATE_EN - when defined the frame counter
// advances once per frame; otherwise it stays 0 (static picture).
// ---------------------------------------------------------------------------
module vga_example
    import vga_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    vga_if.slave   tile
);

    logic [9:0]  hcount_s, vcount_s;
    logic        hsync_s, vsync_s, visible_s, frame_end_s;

    logic [7:0]  frame_q, frame_d;
    pattern_e    sel_q, sel_d;
    logic [7:0]  uo_q, uo_d;

    logic [8:0]  dx_s, dy_s, a_s, b_s;
    logic [17:0] prod_s;
    logic [7:0]  pix_s;
    logic [7:0]  shown_s;
    logic        unused_ok_s;

    vga_timing u_timing (
        .clk       (clk),
        .rst_n     (rst_n),
        .hcount    (hcount_s),
        .vcount    (vcount_s),
        .hsync     (hsync_s),
        .vsync     (vsync_s),
        .visible   (visible_s),
        .frame_end (frame_end_s)
    );

    // Frame counter, pattern select and output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_q <= 8'd0;
            sel_q   <= RINGS;
            uo_q    <= UO_IDLE;
        end else begin
            frame_q <= frame_d;
            sel_q   <= sel_d;
            uo_q    <= uo_d;
        end
    end

    // Frame-boundary updates: select only changes between frames so a
    // pattern switch never tears the picture.
    always_comb begin
        if (frame_end_s) begin
            sel_d = pattern_e'(tile.ui_in[1:0]);
        end else begin
            sel_d = sel_q;
        end
`ifdef VGA_ANIMATE_EN
        if (frame_end_s) begin
            frame_d = frame_q + 8'd1;
        end else begin
            frame_d = frame_q;
        end
`else
        frame_d = 8'd0;
`endif
    end

    // Fold the pixel onto one octant: a is the larger, b the smaller distance.
    always_comb begin
        dx_s = abs_diff(hcount_s, H_CENTRE);
        dy_s = abs_diff(vcount_s, V_CENTRE);
        if (dx_s >= dy_s) begin
            a_s = dx_s;
            b_s = dy_s;
        end else begin
            a_s = dy_s;
            b_s = dx_s;
        end
        prod_s = 18'(a_s) * 18'(b_s);
    end

    // Pattern value; every result wraps to 8 bits.
    always_comb begin
        case (sel_q)
            RINGS:   pix_s = a_s[7:0] + b_s[7:0] + frame_q;
            XOR:     pix_s = (a_s[7:0] ^ b_s[7:0]) + frame_q;
            PRODUCT: pix_s = prod_s[13:6] + frame_q;
            SQUARE:  pix_s = a_s[7:0] - frame_q;
            default: pix_s = 8'd0;
        endcase
    end

    // Blanking and pin packing: R={v7,v4}, G={v6,v3}, B={v5,v2}.
    always_comb begin
        if (visible_s) begin
            shown_s = pix_s;
        end else begin
            shown_s = 8'd0;
        end
        uo_d = {hsync_s, shown_s[2], shown_s[3], shown_s[4],
                vsync_s, shown_s[5], shown_s[6], shown_s[7]};
    end

    assign tile.uo_out  = uo_q;
    assign tile.uio_out = 8'h00;
    assign tile.uio_oe  = 8'h00;

    // Inputs and product bits that intentionally have no effect.
    assign unused_ok_s = &{1'b0, tile.ena, tile.ui_in[7:2], tile.uio_in,
                           prod_s[17:14], prod_s[5:0], a_s[8], b_s[8],
                           shown_s[1:0]};

endmodule

// File: tb/tb_vga_example.sv
// ---------------------------------------------------------------------------
// tb_vga_example
// Self-checking bench for vga_example. A pixel-level reference model derives
// the expected output word from the raster position, frame number and the
// pattern select in force; a table of hand-computed pixels and a few
// multi-cycle sequences (sync widths, frame period, pattern switching,
// mid-frame reset) complement it.
// ---------------------------------------------------------------------------
module tb_vga_example;

    localparam int FRAME_CYC = 420000;
    localparam int LINE_CYC  = 800;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    // model state: t = raster index of the pixel the DUT currently holds
    int   t;
    int   frame_m;
    int   sel_m;

    vga_if bus ();

    vga_example dut (
        .clk   (clk),
        .rst_n (rst_n),
        .tile  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         h;
        int         v;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl [12];

    // Expected output word for a pixel, from the mandala rules.
    function automatic logic [7:0] exp_uo(input int h, input int v, input int f, input int s);
        int dx, dy, a, b, val;
        logic [7:0] vv;
        bit hs, vs;
        dx = (h >= 320) ? h - 320 : 320 - h;
        dy = (v >= 240) ? v - 240 : 240 - v;
        a  = (dx > dy) ? dx : dy;
        b  = (dx > dy) ? dy : dx;
        case (s)
            0:       val = a + b + f;
            1:       val = (a ^ b) + f;
            2:       val = ((a * b) / 64) + f;
            default: val = (a % 256) - f;
        endcase
        vv = 8'(val);
        if (!(h < 640 && v < 480)) vv = 8'd0;
        hs = !(h >= 656 && h < 752);
        vs = !(v >= 490 && v < 492);
        return {hs, vv[2], vv[3], vv[4], vs, vv[5], vv[6], vv[7]};
    endfunction

    task automatic check8(input string name, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", name, got, want);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    // One clock: compare against the model, then advance the model.
    task automatic step();
        int h, v;
        logic [7:0] want;
        @(posedge clk);
        #1;
        h = t % LINE_CYC;
        v = (t / LINE_CYC) % 525;
        want = exp_uo(h, v, frame_m, sel_m);
        checks++;
        if (bus.uo_out !== want) begin
            errors++;
            $display("FAIL pixel t=%0d h=%0d v=%0d f=%0d sel=%0d: got %02h expected %02h",
                     t, h, v, frame_m, sel_m, bus.uo_out, want);
        end
        if (h == 799 && v == 524) begin
            sel_m = int'(bus.ui_in[1:0]);
`ifdef VGA_ANIMATE_EN
            frame_m = (frame_m + 1) % 256;
`endif
        end
        t = t + 1;
    endtask

    initial begin
        int  n_total;
        int  hs_low, vs_low, blank_bad;
        int  hs_first_fall, vs_fall0, vs_fall1;
        bit  prev_hs, prev_vs;
        int  p, ph, pv;
        logic [7:0] e330_f1, e330_f2;

        checks = 0;
        errors = 0;

        // Hand-computed pixels in frame 0 with the RINGS pattern.
        tbl[0]  = '{320, 240, 8'h88};
        tbl[1]  = '{330, 245, 8'hE8};
        tbl[2]  = '{0,   0,   8'h9C};
        tbl[3]  = '{639, 0,   8'hEC};
        tbl[4]  = '{640, 0,   8'h88};
        tbl[5]  = '{656, 0,   8'h08};
        tbl[6]  = '{751, 0,   8'h08};
        tbl[7]  = '{752, 0,   8'h88};
        tbl[8]  = '{325, 240, 8'hC8};
        tbl[9]  = '{320, 100, 8'hE9};
        tbl[10] = '{0,   490, 8'h80};
        tbl[11] = '{0,   492, 8'h88};

`ifdef VGA_ANIMATE_EN
        e330_f1 = 8'h98;   // XOR: 15 + 1 = 16
        e330_f2 = 8'h88;   // PRODUCT: (50>>6) + 2 = 2
`else
        e330_f1 = 8'hE8;   // XOR: 15
        e330_f2 = 8'h88;   // PRODUCT: 0
`endif

        // Reset state
        rst_n      = 1'b0;
        bus.ena    = 1'b0;
        bus.ui_in  = 8'h00;
        bus.uio_in = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check8("reset_uo_out", bus.uo_out, 8'h88);
        check8("reset_uio_out", bus.uio_out, 8'h00);
        check8("reset_uio_oe", bus.uio_oe, 8'h00);

        rst_n   = 1'b1;
        t       = 0;
        frame_m = 0;
        sel_m   = 0;

        hs_low = 0; vs_low = 0; blank_bad = 0;
        hs_first_fall = -1; vs_fall0 = -1; vs_fall1 = -1;
        prev_hs = 1'b1; prev_vs = 1'b1;
        n_total = 2 * FRAME_CYC + 2000;

        for (int n = 1; n <= n_total; n++) begin
            step();
            p  = n - 1;
            ph = p % LINE_CYC;
            pv = (p / LINE_CYC) % 525;

            if (n <= 2 * LINE_CYC) begin
                if (bus.uo_out[7] == 1'b0) hs_low++;
                if (prev_hs && !bus.uo_out[7] && hs_first_fall < 0) hs_first_fall = n;
            end
            if (n <= FRAME_CYC) begin
                if (bus.uo_out[3] == 1'b0) vs_low++;
                if (!(ph < 640 && pv < 480) && ((bus.uo_out & 8'h77) != 8'h00)) blank_bad++;
                for (int i = 0; i < 12; i++) begin
                    if (p == tbl[i].v * LINE_CYC + tbl[i].h)
                        check8($sformatf("table_%0d_%0d", tbl[i].h, tbl[i].v), bus.uo_out, tbl[i].exp);
                end
            end
            if (p == FRAME_CYC + 245 * LINE_CYC + 330)
                check8("pix330_245_frame1", bus.uo_out, e330_f1);
            if (p == 2 * FRAME_CYC + 245 * LINE_CYC + 330)
                check8("pix330_245_frame2", bus.uo_out, e330_f2);
            if (prev_vs && !bus.uo_out[3]) begin
                if (vs_fall0 < 0) vs_fall0 = n;
                else if (vs_fall1 < 0) vs_fall1 = n;
            end
            prev_hs = bus.uo_out[7];
            prev_vs = bus.uo_out[3];

            // Drive inputs for the next edge; ignored pins always random.
            bus.ena    = 1'($urandom);
            bus.uio_in = 8'($urandom);
            bus.ui_in[7:2] = 6'($urandom);
            if (n < 200000 || (n > FRAME_CYC && n < 620000))
                bus.ui_in[1:0] = 2'($urandom_range(0, 3));
            else if (n < FRAME_CYC)
                bus.ui_in[1:0] = 2'd1;
            else if (n < 2 * FRAME_CYC)
                bus.ui_in[1:0] = 2'd2;
            else
                bus.ui_in[1:0] = 2'($urandom_range(0, 3));
        end

        check_int("hsync_low_2_lines", hs_low, 192);
        check_int("hsync_first_fall", hs_first_fall, 657);
        check_int("vsync_low_frame", vs_low, 1600);
        check_int("vsync_first_fall", vs_fall0, 490 * LINE_CYC + 1);
        check_int("vsync_period", vs_fall1 - vs_fall0, FRAME_CYC);
        check_int("blank_rgb_nonzero", blank_bad, 0);

        // Mid-frame reset: asynchronous return to idle, then a fresh start.
        rst_n = 1'b0;
        #1;
        check8("async_reset_uo_out", bus.uo_out, 8'h88);
        repeat (2) @(posedge clk);
        #1;
        check8("held_reset_uo_out", bus.uo_out, 8'h88);
        rst_n   = 1'b1;
        t       = 0;
        frame_m = 0;
        sel_m   = 0;
        bus.ui_in = 8'h03;
        hs_first_fall = -1;
        prev_hs = 1'b1;
        for (int n = 1; n <= 1000; n++) begin
            step();
            if (prev_hs && !bus.uo_out[7] && hs_first_fall < 0) hs_first_fall = n;
            prev_hs = bus.uo_out[7];
        end
        check_int("hsync_fall_after_reset", hs_first_fall, 657);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
